// File: rtl/uart_wb_poller.sv
// WISHBONE master for the MiniUART: programs the baud divisors, then polls LSR,
// moving received bytes into a local FIFO and host bytes into the TX register.
module uart_wb_poller #(
  parameter logic [15:0] DIV_RX   = 16'd326,
  parameter logic [15:0] DIV_TX   = 16'd5208,
  parameter int          FIFO_AW  = 3,
  parameter int          TX_GUARD = 4
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  output logic [6:2]         ADD_O,
  output logic [31:0]        DAT_O,
  input  logic [31:0]        DAT_I,
  output logic               STB_O,
  output logic               WE_O,
  input  logic               ACK_I,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [7:0]         tx_byte,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [7:0]         rx_byte,
  output logic [FIFO_AW:0]   rx_count,
  output logic               init_done
);

  // state     | meaning
  // INIT_DIVR | write RX baud divisor
  // INIT_DIVT | write TX baud divisor
  // POLL      | read LSR and pick the next transfer
  // RD_RX     | read received byte into the FIFO
  // CLR_RX    | dummy write to LSR that clears rs
  // WR_TX     | write the held byte to the TX register
  typedef enum logic [2:0] {INIT_DIVR, INIT_DIVT, POLL, RD_RX, CLR_RX, WR_TX} state_t;

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int GW    = $clog2(TX_GUARD + 1);

  state_t             state, state_nxt;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   cnt;
  logic               hold_full;
  logic [7:0]         hold_byte;
  logic [GW-1:0]      guard;
  logic               rr, init_q;
  logic [4:0]         bus_adr;
  logic [31:0]        bus_dat;
  logic               bus_we;
  logic               done, push, pop, load, rx_ok, tx_ok, tx_done;
  logic               unused_dat;

  assign unused_dat = ^DAT_I[31:8];

  assign done    = ~RST_I & ACK_I;
  assign push    = done && (state == RD_RX);
  assign tx_done = done && (state == WR_TX);
  assign pop     = rx_ready && (cnt != '0);
  assign load    = tx_valid && init_q && !hold_full;
  // FIFO is full exactly when the count MSB is set
  assign rx_ok   = DAT_I[0] && !cnt[FIFO_AW];
  assign tx_ok   = DAT_I[5] && hold_full && (guard == '0);

  always_comb begin
    state_nxt = state;
    bus_adr   = 5'b01000;
    bus_we    = 1'b0;
    bus_dat   = '0;
    case (state)
      INIT_DIVR: begin
        bus_adr = 5'b01001;
        bus_we  = 1'b1;
        bus_dat = {16'b0, DIV_RX};
        if (ACK_I) state_nxt = INIT_DIVT;
      end
      INIT_DIVT: begin
        bus_adr = 5'b01010;
        bus_we  = 1'b1;
        bus_dat = {16'b0, DIV_TX};
        if (ACK_I) state_nxt = POLL;
      end
      POLL: begin
        if (ACK_I) begin
          if (rx_ok && tx_ok) state_nxt = rr ? WR_TX : RD_RX;
          else if (rx_ok)     state_nxt = RD_RX;
          else if (tx_ok)     state_nxt = WR_TX;
        end
      end
      RD_RX: begin
        bus_adr = 5'b00100;
        if (ACK_I) state_nxt = CLR_RX;
      end
      CLR_RX: begin
        bus_we = 1'b1;
        if (ACK_I) state_nxt = POLL;
      end
      WR_TX: begin
        bus_adr = 5'b00100;
        bus_we  = 1'b1;
        bus_dat = {24'b0, hold_byte};
        if (ACK_I) state_nxt = POLL;
      end
      default: state_nxt = INIT_DIVR;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= INIT_DIVR;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      hold_byte <= '0;
      guard     <= '0;
      rr        <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (tx_done) begin
        hold_full <= 1'b0;
      end else if (load) begin
        hold_full <= 1'b1;
        hold_byte <= tx_byte;
      end
      if (tx_done)            guard <= GW'(TX_GUARD);
      else if (guard != '0)   guard <= guard - 1'b1;
      if (push)               rr <= 1'b1;
      else if (tx_done)       rr <= 1'b0;
      if (done && state == INIT_DIVT) init_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem[wptr] <= DAT_I[7:0];
  end

  assign STB_O     = ~RST_I;
  assign WE_O      = ~RST_I & bus_we;
  assign ADD_O     = RST_I ? 5'b0 : bus_adr;
  assign DAT_O     = RST_I ? 32'b0 : bus_dat;
  assign init_done = ~RST_I & init_q;
  assign tx_ready  = ~RST_I & init_q & ~hold_full;
  assign rx_valid  = ~RST_I & (cnt != '0);
  assign rx_count  = RST_I ? '0 : cnt;
  assign rx_byte   = mem[rptr];

endmodule

// File: tb/tb_uart_wb_poller.sv
// Bench for uart_wb_poller: a transaction-level model predicts each bus transfer
// and the FIFO/holding state; directed vectors plus random traffic drive it.
module tb_uart_wb_poller;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [6:2]  ADD_O;
  logic [31:0] DAT_O, DAT_I;
  logic        STB_O, WE_O, ACK_I;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, init_done;
  logic [7:0]  tx_byte, rx_byte;
  logic [3:0]  rx_count;

  uart_wb_poller dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADD_O(ADD_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_byte(tx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_byte(rx_byte),
    .rx_count(rx_count), .init_done(init_done)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int errors = 0;

  // stimulus controls
  bit         rst_req = 1'b1;
  int         ack_mode = 1;      // 0 random, 1 always, 2 never
  bit         lsr_mode = 0, tx_mode = 0, pop_mode = 0, rx_rand = 0;
  logic [7:0] lsr_val = 0, rx_val = 8'hA5, tb_val = 0;
  bit         tv_val = 0, pop_val = 0;

  // reference model
  logic [7:0]  q[$];
  bit          m_full, m_init, m_rr, last_poll;
  logic [7:0]  m_hold;
  int          m_guard;
  logic [4:0]  e_adr;
  bit          e_we;
  logic [31:0] e_dat;

  // snapshot of the cycle's inputs
  bit          s_done, s_load, s_pop;
  logic [31:0] s_dati;
  logic [7:0]  s_tb;

  typedef struct {
    logic [7:0]  lsr;
    bit          load;
    logic [7:0]  byt;
    logic [4:0]  adr;
    bit          we;
    logic [31:0] dat;
  } vec_t;
  vec_t vt[8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_exp(logic [4:0] a, bit w, logic [31:0] d);
    e_adr = a; e_we = w; e_dat = d;
  endtask

  task automatic model_reset();
    q.delete();
    m_full = 0; m_init = 0; m_rr = 0; m_guard = 0; m_hold = 0; last_poll = 0;
    set_exp(5'b01001, 1, 32'd326);
  endtask

  task automatic model_edge();
    int osz, og;
    bit ofull, rx_ok, tx_ok, wr_done;
    osz = q.size(); og = m_guard; ofull = m_full; wr_done = 0; last_poll = 0;
    if (s_done) begin
      if (e_we && e_adr == 5'b01001) set_exp(5'b01010, 1, 32'd5208);
      else if (e_we && e_adr == 5'b01010) begin m_init = 1; set_exp(5'b01000, 0, 0); end
      else if (!e_we && e_adr == 5'b01000) begin
        last_poll = 1;
        rx_ok = s_dati[0] && osz < 8;
        tx_ok = s_dati[5] && ofull && og == 0;
        if (rx_ok && (!tx_ok || !m_rr)) set_exp(5'b00100, 0, 0);
        else if (tx_ok)                 set_exp(5'b00100, 1, {24'b0, m_hold});
        else                            set_exp(5'b01000, 0, 0);
      end else if (!e_we) begin
        q.push_back(s_dati[7:0]); m_rr = 1; set_exp(5'b01000, 1, 0);
      end else if (e_adr == 5'b01000) set_exp(5'b01000, 0, 0);
      else begin wr_done = 1; m_full = 0; m_rr = 0; set_exp(5'b01000, 0, 0); end
    end
    if (s_pop) void'(q.pop_front());
    if (wr_done)     m_guard = 4;
    else if (og > 0) m_guard = og - 1;
    if (s_load) begin m_full = 1; m_hold = s_tb; end
  endtask

  task automatic cycle();
    logic [31:0] r;
    logic [7:0]  lsr;
    @(negedge CLK_I);
    RST_I = rst_req;
    #1;
    ACK_I = STB_O && (ack_mode == 1 || (ack_mode == 0 && $urandom_range(0, 99) < 70));
    r = $urandom;
    if (ADD_O == 5'b01000) begin
      lsr  = lsr_mode ? 8'($urandom) : lsr_val;
      r[0] = lsr[0];
      r[5] = lsr[5];
    end else r[7:0] = rx_rand ? 8'($urandom) : rx_val;
    DAT_I    = r;
    tx_valid = tx_mode ? 1'($urandom_range(0, 1)) : tv_val;
    tx_byte  = tx_mode ? 8'($urandom) : tb_val;
    rx_ready = pop_mode ? ($urandom_range(0, 2) == 0) : pop_val;
    #1;
    if (RST_I) begin
      chk("rst_stb", STB_O, 0);       chk("rst_we", WE_O, 0);
      chk("rst_adr", ADD_O, 0);       chk("rst_dat", DAT_O, 0);
      chk("rst_init", init_done, 0);  chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0); chk("rst_rx_count", rx_count, 0);
    end else begin
      chk("stb", STB_O, 1);
      chk("adr", ADD_O, e_adr);
      chk("we", WE_O, e_we);
      if (e_we) chk("dat", DAT_O, e_dat);
      chk("init_done", init_done, m_init);
      chk("tx_ready", tx_ready, m_init && !m_full);
      chk("rx_valid", rx_valid, q.size() > 0);
      chk("rx_count", rx_count, q.size());
      if (q.size() > 0) chk("rx_byte", rx_byte, q[0]);
    end
    s_done = STB_O && ACK_I;
    s_dati = DAT_I;
    s_load = tx_valid && m_init && !m_full;
    s_tb   = tx_byte;
    s_pop  = rx_ready && q.size() > 0;
    @(posedge CLK_I);
    if (RST_I) model_reset();
    else       model_edge();
  endtask

  task automatic wait_rd(string nm);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 40) begin
      cycle(); #1;
      hit = (ADD_O == 5'b00100) && !WE_O;
      n++;
    end
    chk(nm, hit, 1);
  endtask

  initial begin
    int n, c0;
    bit hit;
    vt[0] = '{8'h00, 0, 8'h00, 5'b01000, 0, 32'h0};
    vt[1] = '{8'h01, 0, 8'h00, 5'b00100, 0, 32'h0};
    vt[2] = '{8'h20, 1, 8'h3C, 5'b00100, 1, 32'h3C};
    vt[3] = '{8'h20, 0, 8'h00, 5'b01000, 0, 32'h0};
    vt[4] = '{8'h21, 1, 8'h55, 5'b00100, 0, 32'h0};
    vt[5] = '{8'h21, 0, 8'h00, 5'b00100, 1, 32'h55};
    vt[6] = '{8'h20, 1, 8'h77, 5'b00100, 1, 32'h77};
    vt[7] = '{8'h01, 0, 8'h00, 5'b00100, 0, 32'h0};
    tx_valid = 0; rx_ready = 0; ACK_I = 0; DAT_I = 0; tx_byte = 0;
    model_reset();

    // reset and divisor programming
    repeat (3) cycle();
    rst_req = 0;
    cycle(); #1;
    chk("init_adr2", ADD_O, 5'b01010);
    chk("init_dat2", DAT_O, 32'd5208);
    chk("init_done_early", init_done, 0);
    cycle(); #1;
    chk("init_done", init_done, 1);
    chk("first_poll_adr", ADD_O, 5'b01000);
    chk("first_poll_we", WE_O, 0);

    // directed LSR vectors
    foreach (vt[i]) begin
      lsr_val = 0; tv_val = 0;
      repeat (10) cycle();
      if (vt[i].load) begin tv_val = 1; tb_val = vt[i].byt; cycle(); tv_val = 0; end
      lsr_val = vt[i].lsr;
      last_poll = 0; n = 0;
      while (!last_poll && n < 20) begin cycle(); n++; end
      chk("vec_poll_seen", last_poll, 1);
      lsr_val = 0;
      #1;
      chk("vec_adr", ADD_O, vt[i].adr);
      chk("vec_we", WE_O, vt[i].we);
      if (vt[i].we) chk("vec_dat", DAT_O, vt[i].dat);
    end

    // TX guard: back-to-back TX with ts held high
    repeat (10) cycle();
    tv_val = 1; tb_val = 8'h3C; cycle();
    tb_val = 8'h3D; lsr_val = 8'h20;
    n = 0; hit = 0;
    while (!hit && n < 20) begin cycle(); #1; hit = (ADD_O == 5'b00100) && WE_O; n++; end
    chk("guard_first_wr", hit, 1);
    n = 0; hit = 0;
    while (!hit && n < 20) begin cycle(); #1; hit = (ADD_O == 5'b00100) && WE_O; n++; end
    chk("guard_gap", n, 6);
    tv_val = 0; lsr_val = 0;
    repeat (10) cycle();

    // FIFO full: only LSR polls, then one pop re-enables RD_RX
    lsr_val = 8'h01; rx_rand = 1; n = 0;
    while (q.size() < 8 && n < 200) begin cycle(); n++; end
    chk("fifo_filled", q.size(), 8);
    repeat (2) cycle();
    repeat (10) begin
      cycle(); #1;
      chk("full_poll_adr", ADD_O, 5'b01000);
      chk("full_count", rx_count, 8);
    end
    pop_val = 1; cycle(); pop_val = 0;
    wait_rd("rd_after_pop");

    // stall in RD_RX, then reset during a stall
    pop_val = 1; lsr_val = 0;
    repeat (20) cycle();
    pop_val = 0; lsr_val = 8'h01;
    wait_rd("rd_for_stall");
    ack_mode = 2; c0 = rx_count;
    repeat (3) begin
      cycle(); #1;
      chk("stall_stb", STB_O, 1);
      chk("stall_adr", ADD_O, 5'b00100);
      chk("stall_count", rx_count, c0);
    end
    ack_mode = 1;
    cycle(); #1;
    chk("stall_push", rx_count, c0 + 1);
    wait_rd("rd_for_reset");
    ack_mode = 2;
    repeat (2) cycle();
    rst_req = 1;
    repeat (2) cycle();
    rst_req = 0; ack_mode = 1; lsr_val = 0;
    cycle(); #1;
    chk("reinit_adr", ADD_O, 5'b01010);
    chk("reinit_count", rx_count, 0);

    // random traffic against the model
    ack_mode = 0; lsr_mode = 1; tx_mode = 1; pop_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      rst_req = (k >= 1500 && k < 1502);
      cycle();
    end
    rst_req = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
